// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit and the main decoder.
package instr_fetch_unit_pkg;

  localparam int          XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          DEPTH_DEFAULT    = 2;

  localparam logic [6:0] OP_LW  = 7'd3;
  localparam logic [6:0] OP_SW  = 7'd35;
  localparam logic [6:0] OP_R   = 7'd51;
  localparam logic [6:0] OP_BEQ = 7'd99;
  localparam logic [6:0] OP_I   = 7'd19;
  localparam logic [6:0] OP_JAL = 7'd111;

  // RUN: every response is on the current path. DRAIN: wrong-path responses still pending.
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } fetch_state_e;

  function automatic logic [6:0] opcode_of(input logic [31:0] word);
    return word[6:0];
  endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Synchronous DEPTH-deep FIFO with flush; used for both the instruction queue and the PC tag queue.
module fetch_fifo
  import instr_fetch_unit_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int WIDTH = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             not_empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign not_empty = (count_q != '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  // Next pointer/count values; flush wins over any push or pop in the same cycle.
  always_comb begin
    do_pop   = pop && not_empty;
    do_push  = push && (!full || do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  overflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !do_pop && !flush));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues imem reads under a credit limit, tags them with their PC,
// buffers returned words for decode and discards wrong-path responses after a redirect.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
  parameter int              DEPTH    = DEPTH_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [6:0]      op,
  output logic [XLEN-1:0] instr_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int SUM_W = CNT_W + 1;

  logic [XLEN-1:0]    fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]   drop_q, drop_d;
  fetch_state_e       state_q, state_d;

  logic [CNT_W-1:0]   tag_count;
  logic [XLEN-1:0]    tag_head;
  logic               tag_full;
  logic               tag_not_empty;

  logic [CNT_W-1:0]   iq_count;
  logic [XLEN+31:0]   iq_head;
  logic               iq_full;
  logic               iq_not_empty;

  logic               credit_ok;
  logic               req_accept;
  logic               rsp_keep;
  logic               iq_pop;
  logic [CNT_W-1:0]   outstanding_next;

  // Words in the queue plus reads in flight may never exceed the queue depth.
  assign credit_ok      = (SUM_W'(iq_count) + SUM_W'(tag_count)) < SUM_W'(DEPTH);
  assign imem_req_valid = rst_n && credit_ok && !redirect_valid;
  assign imem_req_addr  = fetch_pc_q;
  assign req_accept     = imem_req_valid && imem_req_ready;
  assign rsp_keep       = imem_rsp_valid && (state_q == ST_RUN);
  assign iq_pop         = instr_valid && instr_ready && !redirect_valid;

  assign instr_valid = iq_not_empty;
  assign instr       = iq_not_empty ? iq_head[31:0] : '0;
  assign instr_pc    = iq_not_empty ? iq_head[XLEN+31:32] : '0;
  assign op          = opcode_of(instr);

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN)) u_tag_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (1'b0),
    .push      (req_accept),
    .push_data (fetch_pc_q),
    .pop       (imem_rsp_valid),
    .head_data (tag_head),
    .not_empty (tag_not_empty),
    .full      (tag_full),
    .count     (tag_count)
  );

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN + 32)) u_instr_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (rsp_keep),
    .push_data ({tag_head, imem_rsp_data}),
    .pop       (iq_pop),
    .head_data (iq_head),
    .not_empty (iq_not_empty),
    .full      (iq_full),
    .count     (iq_count)
  );

  // Next PC and drop count; a redirect marks every read still in flight as wrong-path.
  always_comb begin
    outstanding_next = tag_count + CNT_W'(req_accept) - CNT_W'(imem_rsp_valid);
    fetch_pc_d       = fetch_pc_q;
    drop_d           = drop_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~XLEN'(3);
      drop_d     = outstanding_next;
    end else begin
      if (req_accept) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CNT_W'(1);
    end
    state_d = (drop_d != '0) ? ST_DRAIN : ST_RUN;
  end

  // Fetch PC, drop counter and RUN/DRAIN state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      drop_q     <= '0;
      state_q    <= ST_RUN;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
      state_q    <= state_d;
    end
  end

  rsp_has_tag_chk: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> tag_not_empty);
  req_has_room_chk: assert property (@(posedge clk) disable iff (!rst_n)
    req_accept |-> !tag_full);
  iq_no_overflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
    !(rsp_keep && iq_full && !iq_pop && !redirect_valid));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit with an in-order imem model and a queue-level reference.
module tb_instr_fetch_unit;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [6:0]  op;
  logic [31:0] instr_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .op             (op),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] addr;
    longint      due;
  } pend_t;

  // Reference state: fetch PC, reads in flight, wrong-path reads to discard, queued PCs.
  logic [31:0] mFetchPc;
  int          mOutst;
  int          mDrop;
  logic [31:0] mFifo[$];
  pend_t       pend[$];
  longint      cyc = 0;
  longint      lastDue = 0;
  logic [31:0] acceptedLog[$];
  logic [31:0] deliveredLog[$];

  int          latMin = 1, latMax = 1, pReady = 100, pIready = 100, pRedir = 0;
  bit          dirRedir = 0;
  logic [31:0] dirPc = '0;
  bit          expReqValid;
  bit          rspNow;
  logic [31:0] rspAddr;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] randPc();
    if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
    return 32'($urandom_range(0, 255));
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic failNow(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: got no event want event within cycle budget", name);
  endtask

  task automatic applyStimulus();
    instr_ready    = ($urandom_range(1, 100) <= pIready);
    imem_req_ready = ($urandom_range(1, 100) <= pReady);
    if (dirRedir) begin
      redirect_valid = 1'b1;
      redirect_pc    = dirPc;
      dirRedir       = 0;
    end else if ($urandom_range(1, 100) <= pRedir) begin
      redirect_valid = 1'b1;
      redirect_pc    = randPc();
    end else begin
      redirect_valid = 1'b0;
      redirect_pc    = $urandom;
    end
    rspNow         = 0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      rspNow         = 1;
      rspAddr        = pend[0].addr;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memWord(pend[0].addr);
      void'(pend.pop_front());
    end
  endtask

  task automatic checkOutput();
    logic [31:0] w;
    expReqValid = ((mFifo.size() + mOutst) < DEPTH) && !redirect_valid;
    checkVal("req_valid", 32'(imem_req_valid), 32'(expReqValid));
    if (expReqValid) checkVal("req_addr", imem_req_addr, mFetchPc);
    checkVal("instr_valid", 32'(instr_valid), 32'(mFifo.size() > 0));
    if (mFifo.size() > 0) begin
      w = memWord(mFifo[0]);
      checkVal("instr_pc", instr_pc, mFifo[0]);
      checkVal("instr", instr, w);
      checkVal("op", 32'(op), {25'd0, w[6:0]});
    end
  endtask

  task automatic updateModel();
    bit     acc;
    bit     pop;
    longint due;
    acc = expReqValid && imem_req_ready;
    pop = (mFifo.size() > 0) && instr_ready && !redirect_valid;
    if (acc) begin
      due = cyc + longint'($urandom_range(latMin, latMax));
      if (due <= lastDue) due = lastDue + 1;
      lastDue = due;
      pend.push_back('{addr: mFetchPc, due: due});
      acceptedLog.push_back(mFetchPc);
    end
    if (redirect_valid) begin
      mFifo.delete();
      mDrop    = mOutst + int'(acc) - int'(rspNow);
      mFetchPc = redirect_pc & ~32'd3;
    end else begin
      if (pop) begin
        deliveredLog.push_back(mFifo[0]);
        void'(mFifo.pop_front());
      end
      if (rspNow) begin
        if (mDrop > 0) mDrop--;
        else mFifo.push_back(rspAddr);
      end
      if (acc) mFetchPc = mFetchPc + 32'd4;
    end
    mOutst = mOutst + int'(acc) - int'(rspNow);
    cyc++;
  endtask

  task automatic stepCycle();
    @(negedge clk);
    applyStimulus();
    #1;
    checkOutput();
    updateModel();
  endtask

  task automatic doReset();
    rst_n          = 1'b0;
    instr_ready    = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    #1;
    checkVal("rst_req_valid", 32'(imem_req_valid), 32'd0);
    checkVal("rst_req_addr", imem_req_addr, RESET_PC);
    checkVal("rst_instr_valid", 32'(instr_valid), 32'd0);
    checkVal("rst_instr", instr, 32'd0);
    checkVal("rst_op", 32'(op), 32'd0);
    checkVal("rst_instr_pc", instr_pc, 32'd0);
    repeat (2) @(negedge clk);
    mFetchPc = RESET_PC;
    mOutst   = 0;
    mDrop    = 0;
    mFifo.delete();
    pend.delete();
    acceptedLog.delete();
    deliveredLog.delete();
    lastDue  = cyc;
    dirRedir = 0;
    rst_n    = 1'b1;
  endtask

  initial begin
    #2;
    doReset();

    // Streaming with 1-cycle imem and an always-ready decoder.
    latMin = 1; latMax = 1; pReady = 100; pIready = 100; pRedir = 0;
    for (int i = 0; i < 40 && (deliveredLog.size() < 3 || acceptedLog.size() < 3); i++) stepCycle();
    if (deliveredLog.size() < 3 || acceptedLog.size() < 3) failNow("stream_fill");
    else begin
      checkVal("stream_addr0", acceptedLog[0], 32'h0);
      checkVal("stream_addr1", acceptedLog[1], 32'h4);
      checkVal("stream_addr2", acceptedLog[2], 32'h8);
      checkVal("stream_pc0", deliveredLog[0], 32'h0);
      checkVal("stream_pc1", deliveredLog[1], 32'h4);
      checkVal("stream_pc2", deliveredLog[2], 32'h8);
    end

    // Decoder stalled: two words buffered, no requests, head held at pc 0.
    doReset();
    pIready = 0;
    repeat (6) stepCycle();
    checkVal("stall_head_pc", instr_pc, 32'h0);
    checkVal("stall_valid", 32'(instr_valid), 32'd1);
    checkVal("stall_req_valid", 32'(imem_req_valid), 32'd0);
    checkVal("stall_depth", 32'(mFifo.size()), 32'd2);
    pIready = 100;
    for (int i = 0; i < 20 && deliveredLog.size() < 2; i++) stepCycle();
    if (deliveredLog.size() < 2) failNow("stall_release");
    else begin
      checkVal("stall_out0", deliveredLog[0], 32'h0);
      checkVal("stall_out1", deliveredLog[1], 32'h4);
    end

    // Redirect with two reads in flight at 3-cycle latency.
    doReset();
    latMin = 3; latMax = 3;
    repeat (2) stepCycle();
    checkVal("redir_outst", 32'(mOutst), 32'd2);
    dirRedir = 1; dirPc = 32'h40;
    stepCycle();
    checkVal("redir_drop", 32'(mDrop), 32'd2);
    for (int i = 0; i < 40 && deliveredLog.size() < 1; i++) stepCycle();
    if (deliveredLog.size() < 1) failNow("redir_refetch");
    else checkVal("redir_first_pc", deliveredLog[0], 32'h40);

    // Redirect coinciding with push and pop, misaligned target.
    doReset();
    latMin = 1; latMax = 1;
    repeat (2) stepCycle();
    dirRedir = 1; dirPc = 32'h42;
    stepCycle();
    checkVal("same_cyc_drop", 32'(mDrop), 32'd0);
    deliveredLog.delete();
    stepCycle();
    checkVal("same_cyc_empty", 32'(instr_valid), 32'd0);
    checkVal("same_cyc_addr", imem_req_addr, 32'h40);
    for (int i = 0; i < 20 && deliveredLog.size() < 1; i++) stepCycle();
    if (deliveredLog.size() < 1) failNow("same_cyc_refetch");
    else checkVal("same_cyc_pc", deliveredLog[0], 32'h40);

    // PC wrap at the top of the address space.
    doReset();
    dirRedir = 1; dirPc = 32'hFFFF_FFFC;
    stepCycle();
    for (int i = 0; i < 30 && (acceptedLog.size() < 2 || deliveredLog.size() < 1); i++) stepCycle();
    if (acceptedLog.size() < 2 || deliveredLog.size() < 1) failNow("wrap_progress");
    else begin
      checkVal("wrap_addr0", acceptedLog[0], 32'hFFFF_FFFC);
      checkVal("wrap_addr1", acceptedLog[1], 32'h0);
      checkVal("wrap_pc", deliveredLog[0], 32'hFFFF_FFFC);
    end

    // Random traffic with a reset asserted in the middle of the stream.
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) begin
        latMin  = 1;
        latMax  = $urandom_range(1, 4);
        pReady  = $urandom_range(30, 100);
        pIready = $urandom_range(20, 100);
        pRedir  = $urandom_range(0, 10);
      end
      if (i == 1500) begin
        #3;
        doReset();
        pReady = 100; pRedir = 0;
        for (int k = 0; k < 10 && acceptedLog.size() < 1; k++) stepCycle();
        if (acceptedLog.size() < 1) failNow("midrst_first_req");
        else checkVal("midrst_first_addr", acceptedLog[0], RESET_PC);
      end
      stepCycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
